// File: rtl/csr_pkg.sv
// csr_pkg: shared types and constants for the CSR read-modify-write stage.
//   csr_op_t    - CSR operation encoding (RW / RS / RC).
//   CSR_*       - addresses of the FPU status CSRs and the thread-ID CSRs.
//   csr_is_tid  - true for thread-ID CSRs (result gets the lane index added).
//   csr_is_fpu  - true for FPU status CSRs (subject to the optional FPU fence).
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_t;

  localparam logic [31:0] CSR_FFLAGS = 32'h0000_0001;
  localparam logic [31:0] CSR_FRM    = 32'h0000_0002;
  localparam logic [31:0] CSR_FCSR   = 32'h0000_0003;

  localparam logic [31:0] CSR_WTID   = 32'h0000_0CC0;
  localparam logic [31:0] CSR_LTID   = 32'h0000_0CC1;
  localparam logic [31:0] CSR_GTID   = 32'h0000_0CC2;

  function automatic logic csr_is_tid(input logic [31:0] addr);
    return (addr == CSR_WTID) || (addr == CSR_LTID) || (addr == CSR_GTID);
  endfunction

  function automatic logic csr_is_fpu(input logic [31:0] addr);
    return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
  endfunction

endpackage

// File: rtl/csr_pipe_reg.sv
// csr_pipe_reg: one-entry valid/ready pipeline register.
//   clk, reset  - clock, asynchronous active-low reset (clears valid and data).
//   load        - capture enq_data this cycle (caller guarantees space).
//   space       - register can accept an entry: empty or draining this cycle.
//   valid/ready - downstream handshake.
//   enq_data    - payload captured on load; deq_data - held payload.
module csr_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             space,
  output logic             valid,
  input  logic             ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic [WIDTH-1:0] deq_data
);

  assign space = ~valid | ready;

  // A load in the same cycle as a drain replaces the entry, so the stage
  // sustains one transfer per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      deq_data <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      deq_data <= enq_data;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_rmw_stage.sv
// csr_rmw_stage: CSR execute stage. Performs CSRRW/CSRRS/CSRRC (register and
// immediate forms) against the CSR storage block through its combinational
// read port and registered write port, and returns the old value per lane to
// commit through a one-entry output register.
//   clk, reset                 - clock, asynchronous active-low reset.
//   in_*                       - dispatch request and valid/ready handshake.
//   fpu_pending                - per-warp FPU in-flight flags.
//   csr_read_*                 - read port (data returns combinationally).
//   csr_write_*                - write port (storage updates at the fire edge).
//   out_*                      - registered result and commit handshake.
//   busy                       - in_valid | out_valid, for the cycle counter.
// Optional: define CSR_FPU_FENCE_EN to stall FFLAGS/FRM/FCSR accesses while
// the issuing warp has FPU operations in flight.
module csr_rmw_stage
  import csr_pkg::*;
#(
  parameter int NUM_THREADS   = 4,
  parameter int NUM_WARPS     = 4,
  parameter int UUID_BITS     = 44,
  parameter int CSR_ADDR_BITS = 12,
  parameter int NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [UUID_BITS-1:0]      in_uuid,
  input  logic [NW_BITS-1:0]        in_wid,
  input  logic [NUM_THREADS-1:0]    in_tmask,
  input  logic [31:0]               in_pc,
  input  logic [4:0]                in_rd,
  input  logic                      in_wb,
  input  logic [1:0]                in_op,
  input  logic                      in_use_imm,
  input  logic [4:0]                in_imm,
  input  logic [CSR_ADDR_BITS-1:0]  in_addr,
  input  logic [NUM_THREADS*32-1:0] in_rs1_data,

  input  logic [NUM_WARPS-1:0]      fpu_pending,

  output logic                      csr_read_enable,
  output logic [UUID_BITS-1:0]      csr_read_uuid,
  output logic [CSR_ADDR_BITS-1:0]  csr_read_addr,
  output logic [NW_BITS-1:0]        csr_read_wid,
  input  logic [31:0]               csr_read_data,

  output logic                      csr_write_enable,
  output logic [UUID_BITS-1:0]      csr_write_uuid,
  output logic [CSR_ADDR_BITS-1:0]  csr_write_addr,
  output logic [NW_BITS-1:0]        csr_write_wid,
  output logic [31:0]               csr_write_data,

  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [UUID_BITS-1:0]      out_uuid,
  output logic [NW_BITS-1:0]        out_wid,
  output logic [NUM_THREADS-1:0]    out_tmask,
  output logic [31:0]               out_pc,
  output logic [4:0]                out_rd,
  output logic                      out_wb,
  output logic [NUM_THREADS*32-1:0] out_data,

  output logic                      busy
);

  localparam int DATA_W = NUM_THREADS * 32;
  localparam int PAY_W  = UUID_BITS + NW_BITS + NUM_THREADS + 32 + 5 + 1 + DATA_W;

  csr_op_t           op;
  logic [31:0]       src;
  logic [31:0]       new_val;
  logic              wr_suppress;
  logic              stall;
  logic              space;
  logic              fire;
  logic [DATA_W-1:0] result;
  logic [PAY_W-1:0]  enq_payload;
  logic [PAY_W-1:0]  deq_payload;

  assign op = csr_op_t'(in_op);

  // Source operand: scan lanes from high to low so the lowest active lane
  // wins; lane 0 is the fallback for an empty thread mask.
  always_comb begin
    src = in_rs1_data[31:0];
    for (int unsigned i = NUM_THREADS; i > 0; i--) begin
      if (in_tmask[i-1]) src = in_rs1_data[(i-1)*32 +: 32];
    end
    if (in_use_imm) src = {27'b0, in_imm};
  end

  always_comb begin
    case (op)
      CSR_RS:  new_val = csr_read_data | src;
      CSR_RC:  new_val = csr_read_data & ~src;
      default: new_val = src;
    endcase
  end

  // Set/clear with a zero operand is a pure read.
  assign wr_suppress = ((op == CSR_RS) || (op == CSR_RC)) && (src == '0);

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      result[i*32 +: 32] = csr_read_data + (csr_is_tid(32'(in_addr)) ? 32'(i) : 32'd0);
    end
  end

`ifdef CSR_FPU_FENCE_EN
  // Hold FPU status accesses until the warp's in-flight FPU ops have
  // accumulated their flags.
  assign stall = csr_is_fpu(32'(in_addr)) & fpu_pending[in_wid];
`else
  logic unused_fpu_pending;
  assign unused_fpu_pending = ^fpu_pending;
  assign stall = 1'b0;
`endif

  assign in_ready = space & ~stall;
  assign fire     = in_valid & in_ready;

  assign csr_read_enable  = fire;
  assign csr_read_uuid    = in_uuid;
  assign csr_read_addr    = in_addr;
  assign csr_read_wid     = in_wid;

  assign csr_write_enable = fire & ~wr_suppress;
  assign csr_write_uuid   = in_uuid;
  assign csr_write_addr   = in_addr;
  assign csr_write_wid    = in_wid;
  assign csr_write_data   = new_val;

  assign enq_payload = {in_uuid, in_wid, in_tmask, in_pc, in_rd, in_wb, result};

  csr_pipe_reg #(
    .WIDTH (PAY_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (fire),
    .space    (space),
    .valid    (out_valid),
    .ready    (out_ready),
    .enq_data (enq_payload),
    .deq_data (deq_payload)
  );

  assign {out_uuid, out_wid, out_tmask, out_pc, out_rd, out_wb, out_data} = deq_payload;

  assign busy = in_valid | out_valid;

endmodule

// File: tb/tb_csr_rmw_stage.sv
// Bench for csr_rmw_stage (default 4 threads, 4 warps): directed scenarios
// followed by a randomized run against a behavioural CSR-file model.
module tb_csr_rmw_stage;
  import csr_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [43:0]  in_uuid;
  logic [1:0]   in_wid;
  logic [3:0]   in_tmask;
  logic [31:0]  in_pc;
  logic [4:0]   in_rd;
  logic         in_wb;
  logic [1:0]   in_op;
  logic         in_use_imm;
  logic [4:0]   in_imm;
  logic [11:0]  in_addr;
  logic [127:0] in_rs1_data;
  logic [3:0]   fpu_pending;
  logic         csr_read_enable;
  logic [43:0]  csr_read_uuid;
  logic [11:0]  csr_read_addr;
  logic [1:0]   csr_read_wid;
  logic [31:0]  csr_read_data;
  logic         csr_write_enable;
  logic [43:0]  csr_write_uuid;
  logic [11:0]  csr_write_addr;
  logic [1:0]   csr_write_wid;
  logic [31:0]  csr_write_data;
  logic         out_valid;
  logic         out_ready;
  logic [43:0]  out_uuid;
  logic [1:0]   out_wid;
  logic [3:0]   out_tmask;
  logic [31:0]  out_pc;
  logic [4:0]   out_rd;
  logic         out_wb;
  logic [127:0] out_data;
  logic         busy;

  logic [31:0]  rd_val;
  assign csr_read_data = rd_val;

  csr_rmw_stage #(
    .NUM_THREADS   (4),
    .NUM_WARPS     (4),
    .UUID_BITS     (44),
    .CSR_ADDR_BITS (12)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_uuid          (in_uuid),
    .in_wid           (in_wid),
    .in_tmask         (in_tmask),
    .in_pc            (in_pc),
    .in_rd            (in_rd),
    .in_wb            (in_wb),
    .in_op            (in_op),
    .in_use_imm       (in_use_imm),
    .in_imm           (in_imm),
    .in_addr          (in_addr),
    .in_rs1_data      (in_rs1_data),
    .fpu_pending      (fpu_pending),
    .csr_read_enable  (csr_read_enable),
    .csr_read_uuid    (csr_read_uuid),
    .csr_read_addr    (csr_read_addr),
    .csr_read_wid     (csr_read_wid),
    .csr_read_data    (csr_read_data),
    .csr_write_enable (csr_write_enable),
    .csr_write_uuid   (csr_write_uuid),
    .csr_write_addr   (csr_write_addr),
    .csr_write_wid    (csr_write_wid),
    .csr_write_data   (csr_write_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_uuid         (out_uuid),
    .out_wid          (out_wid),
    .out_tmask        (out_tmask),
    .out_pc           (out_pc),
    .out_rd           (out_rd),
    .out_wb           (out_wb),
    .out_data         (out_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected values for the instruction currently presented.
  logic         e_wen;
  logic [31:0]  e_wdata;
  logic [127:0] e_data;
  logic [43:0]  e_uuid;
  logic [31:0]  e_pc;
  logic [4:0]   e_rd;
  logic         e_wb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference semantics: pick the operand, apply the CSR op to the old value,
  // and build the per-lane result.
  task automatic set_instr(input logic [1:0] op, input logic ui, input logic [4:0] imm,
                           input logic [11:0] addr, input logic [1:0] wid, input logic [3:0] tm,
                           input logic [127:0] rs1, input logic [31:0] old);
    logic [31:0] s;
    int lane;
    bit tid;
    lane = 0;
    for (int i = 0; i < 4; i++) if (tm[i]) begin lane = i; break; end
    s = ui ? {27'd0, imm} : rs1[lane*32 +: 32];
    case (op)
      2'b10:   e_wdata = old | s;
      2'b11:   e_wdata = old & ~s;
      default: e_wdata = s;
    endcase
    e_wen = (op == 2'b01) || (s != 0);
    tid = (addr == 12'(CSR_WTID)) || (addr == 12'(CSR_LTID)) || (addr == 12'(CSR_GTID));
    for (int i = 0; i < 4; i++) e_data[i*32 +: 32] = old + (tid ? i : 0);
    e_uuid = 44'({$urandom(), $urandom()});
    e_pc   = $urandom();
    e_rd   = 5'($urandom());
    e_wb   = 1'($urandom());
    in_valid = 1'b1; in_op = op; in_use_imm = ui; in_imm = imm; in_addr = addr;
    in_wid = wid; in_tmask = tm; in_rs1_data = rs1; rd_val = old;
    in_uuid = e_uuid; in_pc = e_pc; in_rd = e_rd; in_wb = e_wb;
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    chk({tag, ".read_en"}, csr_read_enable, 1'b1);
    chk({tag, ".read_addr"}, csr_read_addr, in_addr);
    chk({tag, ".write_en"}, csr_write_enable, e_wen);
    if (e_wen) chk({tag, ".write_data"}, csr_write_data, e_wdata);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".out_valid"}, out_valid, 1'b1);
    chk({tag, ".out_data"}, out_data, e_data);
    chk({tag, ".out_uuid"}, out_uuid, e_uuid);
    chk({tag, ".out_pc"}, out_pc, e_pc);
    chk({tag, ".out_rd"}, out_rd, e_rd);
    chk({tag, ".out_wb"}, out_wb, e_wb);
    chk({tag, ".out_wid"}, out_wid, in_wid);
    chk({tag, ".out_tmask"}, out_tmask, in_tmask);
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic ui, input logic [4:0] imm,
                       input logic [11:0] addr, input logic [1:0] wid, input logic [3:0] tm,
                       input logic [127:0] rs1, input logic [31:0] old);
    set_instr(op, ui, imm, addr, wid, tm, rs1, old);
    #1 chk_comb(tag);
    @(posedge clk);
    #1 chk_out(tag);
  endtask

  logic [31:0]  store [4][5];
  logic [11:0]  raddr [5];
  logic [127:0] h_data;
  logic [43:0]  h_uuid;
  logic         mvalid;
  logic [127:0] m_data;
  logic [43:0]  m_uuid;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fpu_pending = '0; rd_val = '0;
    in_uuid = '0; in_wid = '0; in_tmask = '0; in_pc = '0; in_rd = '0; in_wb = 1'b0;
    in_op = 2'b01; in_use_imm = 1'b0; in_imm = '0; in_addr = '0; in_rs1_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", out_valid, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.read_en", csr_read_enable, 1'b0);
    chk("reset.write_en", csr_write_enable, 1'b0);
    chk("reset.out_data", out_data, '0);
    chk("reset.out_uuid", out_uuid, '0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed instructions with out_ready held high.
    issue("rw", 2'b01, 1'b0, 5'd0, 12'h340, 2'd0, 4'b0001, {96'd0, 32'h1234}, 32'hAAAA);
    issue("rs_zero", 2'b10, 1'b0, 5'd0, 12'h340, 2'd1, 4'b0010,
          {32'h1, 32'h2, 32'h0, 32'hFFFF}, 32'h55);
    issue("rc_imm", 2'b11, 1'b1, 5'd3, 12'h340, 2'd0, 4'b1111, {4{32'hFFFF_FFFF}}, 32'hF);
    issue("ltid", 2'b10, 1'b0, 5'd0, 12'(CSR_LTID), 2'd2, 4'b1111, '0, 32'd2);
    issue("tmask0", 2'b01, 1'b0, 5'd0, 12'h341, 2'd3, 4'b0000,
          {32'h44, 32'h33, 32'h22, 32'h77}, 32'h9);
    issue("lane2", 2'b10, 1'b0, 5'd0, 12'h342, 2'd0, 4'b1100,
          {32'h8000_0000, 32'h0F00, 32'h1, 32'h2}, 32'h00F0);
    issue("gtid_wrap", 2'b11, 1'b1, 5'd0, 12'(CSR_GTID), 2'd1, 4'b0001, '0, 32'hFFFF_FFFE);

    // Backpressure: the held entry must stay put while out_ready is low.
    h_data = e_data; h_uuid = e_uuid;
    out_ready = 1'b0;
    set_instr(2'b01, 1'b0, 5'd0, 12'h343, 2'd2, 4'b0001, {96'd0, 32'hBEEF}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.read_en", csr_read_enable, 1'b0);
      chk("bp.write_en", csr_write_enable, 1'b0);
      chk("bp.out_valid", out_valid, 1'b1);
      chk("bp.out_data", out_data, h_data);
      chk("bp.out_uuid", out_uuid, h_uuid);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    #1 chk_comb("bp_release");
    @(posedge clk);
    #1 chk_out("bp_release");

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.out_valid", out_valid, 1'b0);
    chk("drain.busy", busy, 1'b0);

`ifdef CSR_FPU_FENCE_EN
    fpu_pending = 4'b0010;
    set_instr(2'b10, 1'b0, 5'd0, 12'(CSR_FFLAGS), 2'd1, 4'b0001, '0, 32'h1F);
    #1;
    chk("fence.in_ready", in_ready, 1'b0);
    chk("fence.read_en", csr_read_enable, 1'b0);
    chk("fence.write_en", csr_write_enable, 1'b0);
    chk("fence.busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("fence.out_valid", out_valid, 1'b0);
    fpu_pending = 4'b0000;
    #1 chk_comb("fence_release");
    @(posedge clk);
    #1 chk_out("fence_release");
    fpu_pending = 4'b0010;
    issue("fence_mstatus", 2'b10, 1'b1, 5'd8, 12'h300, 2'd1, 4'b0001, '0, 32'h0);
    issue("fence_other_warp", 2'b01, 1'b1, 5'd2, 12'(CSR_FRM), 2'd0, 4'b0001, '0, 32'h0);
`else
    fpu_pending = 4'b0010;
    issue("nofence_fflags", 2'b10, 1'b0, 5'd0, 12'(CSR_FFLAGS), 2'd1, 4'b0001, '0, 32'h1F);
`endif
    fpu_pending = 4'b0000;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rand.out_valid", out_valid, 1'b0);

    // Randomized traffic against a model CSR file and output-slot model.
    raddr[0] = 12'h340; raddr[1] = 12'h300; raddr[2] = 12'(CSR_WTID);
    raddr[3] = 12'(CSR_LTID); raddr[4] = 12'(CSR_GTID);
    for (int w = 0; w < 4; w++) for (int a = 0; a < 5; a++) store[w][a] = $urandom();
    mvalid = 1'b0; m_data = '0; m_uuid = '0;
    for (int n = 0; n < 80; n++) begin
      int w, a;
      bit iv, ordy, fire;
      w = $urandom_range(0, 3);
      a = $urandom_range(0, 4);
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      set_instr(2'($urandom_range(1, 3)), 1'($urandom()), 5'($urandom()), raddr[a], 2'(w),
                4'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()}, store[w][a]);
      in_valid = iv; out_ready = ordy;
      fire = iv && (!mvalid || ordy);
      #1;
      chk("rand.in_ready", in_ready, (!mvalid || ordy));
      chk("rand.read_en", csr_read_enable, fire);
      chk("rand.write_en", csr_write_enable, fire && e_wen);
      if (fire && e_wen) chk("rand.write_data", csr_write_data, e_wdata);
      @(posedge clk);
      if (fire) begin
        if (e_wen) store[w][a] = e_wdata;
        mvalid = 1'b1; m_data = e_data; m_uuid = e_uuid;
      end else if (ordy) begin
        mvalid = 1'b0;
      end
      #1;
      chk("rand.out_valid", out_valid, mvalid);
      if (mvalid) begin
        chk("rand.out_data", out_data, m_data);
        chk("rand.out_uuid", out_uuid, m_uuid);
      end
    end

    // Reset while a result is held.
    out_ready = 1'b1;
    issue("pre_reset", 2'b01, 1'b0, 5'd0, 12'h340, 2'd3, 4'b0001, {96'd0, 32'h5A5A}, 32'h1);
    out_ready = 1'b0; in_valid = 1'b0;
    #1 chk("rst_mid.held", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid.out_valid", out_valid, 1'b0);
    chk("rst_mid.out_data", out_data, '0);
    chk("rst_mid.busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.out_valid", out_valid, 1'b0);
    chk("post_rst.read_en", csr_read_enable, 1'b0);
    chk("post_rst.write_en", csr_write_enable, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
